// File: rtl/row_sync_pkg.sv
// rtl/row_sync_pkg.sv - shared state type and default constants for the row sync arbiter
// Purpose: FSM state enum and default parameter values used by row_sync_arbiter.
// Ports: none (package).
package row_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_CORES     = 4;
    localparam int DEF_GRANT_TIMEOUT = 255;

    // Wide enough for the largest allowed GRANT_TIMEOUT (65535).
    localparam int CNT_W = 16;

endpackage

// File: rtl/row_sync_arbiter_rr_priority_pick.sv
// rtl/row_sync_arbiter_rr_priority_pick.sv - combinational round-robin first-set picker
// Purpose: find the first set request bit at or after ptr, wrapping modulo NUM_CORES.
// Ports:
//   req   - request vector, one bit per core
//   ptr   - starting index for the search (must be < NUM_CORES)
//   valid - high when any request bit is set
//   index - selected core index (0 when valid is low)
module rr_priority_pick #(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic                 valid,
    output logic [IDX_W-1:0]     index
);

    int cand;

    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = 0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_CORES) begin
                cand = cand - NUM_CORES;
            end
            // First hit wins; later hits are ignored via the valid flag.
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/row_sync_arbiter.sv
// rtl/row_sync_arbiter.sv - round-robin grant arbiter for one row of cores sharing a URAM
// Purpose: grants the shared row buffer to one core at a time, holds it while the core
//          is locked, revokes idle grants after GRANT_TIMEOUT cycles and waits for the
//          URAM to drain before rearbitrating.
// Ports:
//   clk, reset_n     - clock, asynchronous active-low reset
//   i_core_req       - per-core request levels
//   i_core_locked    - per-core locked levels
//   i_uram_empty     - shared buffer holds no pending data
//   o_core_grant     - one-hot-or-zero grant
//   o_uram_emptied   - registered i_uram_empty per core, zero while LOCKED
//   o_owner          - index of current/last grant holder
//   o_busy           - arbiter not idle (registered)
//   o_timeout        - one-cycle pulse when a grant is revoked by timeout (registered)
module row_sync_arbiter
    import row_sync_pkg::*;
#(
    parameter int NUM_CORES     = DEF_NUM_CORES,
    parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_CORES-1:0]         i_core_req,
    input  logic [NUM_CORES-1:0]         i_core_locked,
    input  logic                         i_uram_empty,
    output logic [NUM_CORES-1:0]         o_core_grant,
    output logic [NUM_CORES-1:0]         o_uram_emptied,
    output logic [$clog2(NUM_CORES)-1:0] o_owner,
    output logic                         o_busy,
    output logic                         o_timeout
);

    localparam int IDX_W = $clog2(NUM_CORES);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] next_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      cnt_next;
    logic             timeout_hit;
    logic             rel_by_timeout;
    logic             busy_q;
    logic             timeout_q;
    logic             empty_q;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic             own_req;
    logic             own_locked;

    rr_priority_pick #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req   (i_core_req),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    // Only the owner's bits matter once a grant is out.
    assign own_req    = i_core_req[owner_q];
    assign own_locked = i_core_locked[owner_q];

    // cnt_q is 0 in the first GRANT cycle, so this fires after exactly
    // GRANT_TIMEOUT cycles of grant.
    assign cnt_next    = {{(32 - CNT_W){1'b0}}, cnt_q} + 32'd1;
    assign timeout_hit = (cnt_next >= 32'(GRANT_TIMEOUT));

    assign next_ptr = (owner_q == IDX_W'(NUM_CORES - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        rel_by_timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Locked takes priority over a simultaneous request drop.
                if (own_locked) begin
                    state_d = ST_LOCKED;
                end else if (!own_req) begin
                    state_d = ST_RELEASE;
                end else if (timeout_hit) begin
                    state_d        = ST_RELEASE;
                    rel_by_timeout = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (!own_locked && !own_req) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (i_uram_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            empty_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && pick_valid) begin
                owner_q <= pick_idx;
            end
            if (state_q == ST_RELEASE) begin
                rr_ptr_q <= next_ptr;
            end
            if (state_q == ST_GRANT) begin
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
            busy_q    <= (state_d != ST_IDLE);
            timeout_q <= rel_by_timeout;
            empty_q   <= i_uram_empty;
        end
    end

    // Grant decoded from registered state so reset removes it immediately.
    always_comb begin
        o_core_grant = '0;
        if (state_q == ST_GRANT || state_q == ST_LOCKED) begin
            o_core_grant[owner_q] = 1'b1;
        end
    end

    assign o_uram_emptied = (state_q == ST_LOCKED) ? '0 : {NUM_CORES{empty_q}};
    assign o_owner        = owner_q;
    assign o_busy         = busy_q;
    assign o_timeout      = timeout_q;

endmodule

// File: doc/row_sync_arbiter.md
ROW_SYNC_ARBITER -- requirements
Module: row_sync_arbiter

Interface
REQ-001 Parameter NUM_CORES, default 4, number of cores in one row (2..16).
REQ-002 Parameter GRANT_TIMEOUT, default 255, cycles a granted core may hold the grant without asserting locked (1..65535).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_core_req  input  NUM_CORES  per-core request level; bit k = core k request register.
REQ-006 i_core_locked  input  NUM_CORES  per-core locked level; bit k = core k locked register.
REQ-007 i_uram_empty  input  1  level from the row URAM; high when the shared buffer holds no pending data.
REQ-008 o_core_grant  output  NUM_CORES  one-hot-or-zero grant, bit k feeds core k grant register.
REQ-009 o_uram_emptied  output  NUM_CORES  per-core barrier flag, one bit per core's URAM-emptied read-only register.
REQ-010 o_owner  output  $clog2(NUM_CORES)  index of current/last grant holder.
REQ-011 o_busy  output  1  high in any state other than IDLE.
REQ-012 o_timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-013 FSM states SHALL be IDLE, GRANT, LOCKED, RELEASE.
REQ-014 IDLE: if any i_core_req bit set, select first set bit at or after rr_ptr (wrapping modulo NUM_CORES), load o_owner, go to GRANT; o_core_grant[owner] SHALL rise on the following edge (1-cycle request-to-grant latency).
REQ-015 IDLE with no request: remain IDLE, o_core_grant all zero.
REQ-016 GRANT: o_core_grant = one-hot(owner); if i_core_locked[owner] -> LOCKED; else if !i_core_req[owner] -> RELEASE; else if timeout counter reaches GRANT_TIMEOUT -> RELEASE with o_timeout pulse.
REQ-017 Timeout counter SHALL clear on entry to GRANT, increment each GRANT cycle, saturate, and not run in other states.
REQ-018 Simultaneous locked and req drop in GRANT: locked wins (go LOCKED).
REQ-019 LOCKED: hold grant; when i_core_locked[owner] and i_core_req[owner] are both low -> RELEASE; no timeout in LOCKED.
REQ-020 RELEASE: o_core_grant all zero; rr_ptr <= owner+1 (wrap to 0 after NUM_CORES-1); return to IDLE only when i_uram_empty is high, else wait.
REQ-021 Requests/locked bits from non-owner cores SHALL be ignored outside IDLE; at most one grant bit SHALL ever be set.
REQ-022 o_uram_emptied SHALL be i_uram_empty registered one cycle and replicated to all bits, forced zero while state is LOCKED.
REQ-023 A core dropping req in the same cycle it would be selected in IDLE SHALL NOT be granted (selection uses current-cycle inputs only).
REQ-024 o_busy and o_timeout SHALL be registered.

Reset
REQ-025 On reset_n low, asynchronously: state IDLE, o_core_grant 0, o_uram_emptied 0, o_owner 0, rr_ptr 0, counter 0, o_busy 0, o_timeout 0.
REQ-026 Reset asserted mid-LOCKED SHALL drop the grant immediately; after release the first request is served from rr_ptr 0.

Structure
REQ-027 State enum type and default NUM_CORES/GRANT_TIMEOUT constants SHALL live in shared package row_sync_pkg.
REQ-028 Round-robin selection SHALL be a sub-module rr_priority_pick (inputs req vector and pointer, outputs valid and index), purely combinational.

Verification
REQ-029 Cores 1 and 3 request same cycle after reset -> grant[1] next cycle; after core 1 clears locked/req and i_uram_empty=1, grant[3] within 3 cycles.
REQ-030 Core 0 requested, never locks, GRANT_TIMEOUT=8 -> grant[0] held 8 cycles, o_timeout pulse, grant drops, rr_ptr=1.
REQ-031 Core 2 locked, i_uram_empty=0 at release -> FSM holds RELEASE with zero grants until i_uram_empty=1, then IDLE.
REQ-032 All 4 cores request continuously, each locks/unlocks -> grant order 0,1,2,3,0; never two grant bits high.
REQ-033 reset_n pulled low while core 1 LOCKED -> o_core_grant=0 same cycle (async), o_owner=0.
REQ-034 i_uram_empty=1 while LOCKED -> o_uram_emptied=0; after RELEASE -> all bits 1 one cycle later.
